// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, data width and the
// board-default clock/baud constants used by both transmitter and receiver.
package uart_pkg;

    localparam int UART_DATA_W   = 8;
    localparam int UART_CLK_FREQ = 50_000_000;
    localparam int UART_BAUD     = 115_200;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-cell cycle counter: counts 0..CLKS_PER_BIT-1 while enabled, wraps at
// every bit boundary and flags the last cycle of a cell with bit_end.
module uart_baud_cnt #(
    parameter int CLKS_PER_BIT = 434,
    parameter int CNT_W        = 9
) (
    input  logic i_clk,
    input  logic w_rst,
    input  logic en,
    input  logic clr,
    output logic bit_end
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;

    // Last cycle of the current bit cell.
    assign bit_end = en && (cnt_q == LAST);

    // Cycle counter with synchronous clear and wrap at the cell boundary.
    // NOTE: state uses non-blocking assignments and an asynchronous reset in the
    // sensitivity list, so every flop settles to its reset value without a clock.
    always_ff @(posedge i_clk or posedge w_rst) begin
        if (w_rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// 8-bit UART transmitter, LSB first, start + 8 data + STOP_BITS stop bits.
// Optional parity bit after the data bits when UART_TX_PARITY_EN is defined.
// Byte intake is a valid/ready handshake; all outputs are registered.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ     = UART_CLK_FREQ,
    parameter int BAUD         = UART_BAUD,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic                   i_clk,
    input  logic                   w_rst,
    input  logic [UART_DATA_W-1:0] i_tx_data,
    input  logic                   i_tx_valid,
    output logic                   o_tx_ready,
    output logic                   o_tx,
    output logic                   o_tx_busy,
    output logic                   o_tx_done
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT * STOP_BITS);

    if (CLKS_PER_BIT < 2) begin : g_bad_cpb
        $error("uart_tx: CLKS_PER_BIT must be at least 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $error("uart_tx: STOP_BITS must be 1 or 2");
    end
    if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_par
        $error("uart_tx: PARITY_ODD must be 0 or 1");
    end

    tx_state_t              state_q, state_nxt;
    logic [UART_DATA_W-1:0] shift_q, shift_nxt;
    logic [2:0]             bit_q, bit_nxt;
    logic                   tx_q, tx_nxt;
    logic                   ready_q, ready_nxt;
    logic                   busy_q, busy_nxt;
    logic                   done_q, done_nxt;
    logic                   accept;
    logic                   bit_end;

    assign accept = i_tx_valid && ready_q;

    uart_baud_cnt #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .CNT_W        (CNT_W)
    ) u_baud_cnt (
        .i_clk   (i_clk),
        .w_rst   (w_rst),
        .en      (state_q != IDLE),
        .clr     (accept),
        .bit_end (bit_end)
    );

`ifdef UART_TX_PARITY_EN
    logic parity_q;

    // Parity of the byte captured at acceptance, so later data changes are harmless.
    always_ff @(posedge i_clk or posedge w_rst) begin
        if (w_rst) begin
            parity_q <= 1'b0;
        end else if (accept) begin
            parity_q <= (^i_tx_data) ^ 1'(PARITY_ODD);
        end
    end
`endif

    // State and output registers; the line idles high out of reset.
    always_ff @(posedge i_clk or posedge w_rst) begin
        if (w_rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            bit_q   <= '0;
            tx_q    <= 1'b1;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_nxt;
            shift_q <= shift_nxt;
            bit_q   <= bit_nxt;
            tx_q    <= tx_nxt;
            ready_q <= ready_nxt;
            busy_q  <= busy_nxt;
            done_q  <= done_nxt;
        end
    end

    // Next-state and next-output logic, advancing one step per bit boundary.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        state_nxt = state_q;
        shift_nxt = shift_q;
        bit_nxt   = bit_q;
        tx_nxt    = tx_q;
        ready_nxt = ready_q;
        done_nxt  = 1'b0;

        case (state_q)
            IDLE: begin
                tx_nxt    = 1'b1;
                ready_nxt = 1'b1;
                if (accept) begin
                    shift_nxt = i_tx_data;
                    ready_nxt = 1'b0;
                    tx_nxt    = 1'b0;
                    bit_nxt   = '0;
                    state_nxt = START;
                end
            end
            START: begin
                if (bit_end) begin
                    tx_nxt    = shift_q[0];
                    shift_nxt = {1'b0, shift_q[UART_DATA_W-1:1]};
                    bit_nxt   = '0;
                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_q == 3'(UART_DATA_W - 1)) begin
                        bit_nxt = '0;
`ifdef UART_TX_PARITY_EN
                        tx_nxt    = parity_q;
                        state_nxt = PARITY;
`else
                        tx_nxt    = 1'b1;
                        state_nxt = STOP;
`endif
                    end else begin
                        tx_nxt    = shift_q[0];
                        shift_nxt = {1'b0, shift_q[UART_DATA_W-1:1]};
                        bit_nxt   = bit_q + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    tx_nxt    = 1'b1;
                    bit_nxt   = '0;
                    state_nxt = STOP;
                end
            end
`endif
            STOP: begin
                tx_nxt = 1'b1;
                if (bit_end) begin
                    if (bit_q == 3'(STOP_BITS - 1)) begin
                        done_nxt  = 1'b1;
                        ready_nxt = 1'b1;
                        bit_nxt   = '0;
                        state_nxt = IDLE;
                    end else begin
                        bit_nxt = bit_q + 1'b1;
                    end
                end
            end
            default: begin
                tx_nxt    = 1'b1;
                state_nxt = IDLE;
            end
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

    assign o_tx       = tx_q;
    assign o_tx_ready = ready_q;
    assign o_tx_busy  = busy_q;
    assign o_tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed testbench for uart_tx with CLKS_PER_BIT = 4. Three instances:
// [0] STOP_BITS=1 even parity, [1] STOP_BITS=2, [2] STOP_BITS=1 odd parity.
// Parity expectations follow UART_TX_PARITY_EN when it is defined.
module tb_uart_tx;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic       i_clk;
    logic       w_rst;
    logic [7:0] data;
    logic [2:0] valid;
    logic [2:0] ready;
    logic [2:0] tx;
    logic [2:0] busy;
    logic [2:0] done;

    int n_cmp = 0;
    int n_bad = 0;

    uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(1), .PARITY_ODD(0)) dut0 (
        .i_clk(i_clk), .w_rst(w_rst), .i_tx_data(data), .i_tx_valid(valid[0]),
        .o_tx_ready(ready[0]), .o_tx(tx[0]), .o_tx_busy(busy[0]), .o_tx_done(done[0]));

    uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(2), .PARITY_ODD(0)) dut1 (
        .i_clk(i_clk), .w_rst(w_rst), .i_tx_data(data), .i_tx_valid(valid[1]),
        .o_tx_ready(ready[1]), .o_tx(tx[1]), .o_tx_busy(busy[1]), .o_tx_done(done[1]));

    uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(1), .PARITY_ODD(1)) dut2 (
        .i_clk(i_clk), .w_rst(w_rst), .i_tx_data(data), .i_tx_valid(valid[2]),
        .o_tx_ready(ready[2]), .o_tx(tx[2]), .o_tx_busy(busy[2]), .o_tx_done(done[2]));

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Hard stop in case anything wedges.
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Move to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Expected line level in bit cell k of a frame carrying b.
    function automatic logic exp_cell(input int k, input logic [7:0] b, input logic odd);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        if (PAR == 1 && k == 9) return (^b) ^ odd;
        return 1'b1;
    endfunction

    // Present b on instance sel, wait for acceptance, then check every cycle of
    // the frame, the done pulse and ready return. poke_at >= 0 pulses a 0xFF
    // request during the frame that must be ignored.
    task automatic run_frame(input string tag, input int sel, input logic [7:0] b,
                             input bit keep, input int poke_at, output int waited);
        int   stop  = (sel == 1) ? 2 : 1;
        logic odd   = (sel == 2);
        int   flen  = (10 + PAR + stop - 1) * CPB;
        int   early_done  = 0;
        int   early_ready = 0;
        int   tx_bad      = 0;
        waited = 0;
        data = b;
        valid[sel] = 1'b1;
        while (!ready[sel] && waited < 200) begin
            tick();
            waited++;
        end
        check({tag, " ready_seen"}, 32'(waited < 200), 32'd1);
        tick();                              // acceptance edge
        data = ~b;                           // latched copy must be used
        if (!keep) valid[sel] = 1'b0;
        check({tag, " busy_after_accept"}, 32'(busy[sel]), 32'd1);
        check({tag, " ready_after_accept"}, 32'(ready[sel]), 32'd0);
        for (int c = 0; c < flen; c++) begin
            if (tx[sel] !== exp_cell(c / CPB, b, odd)) begin
                tx_bad++;
                $display("FAIL %s tx@%0d: got %0b expected %0b", tag, c, tx[sel],
                         exp_cell(c / CPB, b, odd));
            end
            if (done[sel]) early_done++;
            if (ready[sel]) early_ready++;
            if (c == poke_at) begin
                data = 8'hFF;
                valid[sel] = 1'b1;
            end
            if (c == poke_at + 1) valid[sel] = 1'b0;
            if (c < flen - 1) tick();
        end
        check({tag, " tx_cells_bad"}, 32'(tx_bad), 32'd0);
        check({tag, " no_early_done"}, 32'(early_done), 32'd0);
        check({tag, " ready_low_in_frame"}, 32'(early_ready), 32'd0);
        tick();                              // edge number flen after acceptance
        check({tag, " done_pulse"}, 32'(done[sel]), 32'd1);
        check({tag, " ready_back"}, 32'(ready[sel]), 32'd1);
        check({tag, " tx_idle"}, 32'(tx[sel]), 32'd1);
        check({tag, " busy_clear"}, 32'(busy[sel]), 32'd0);
    endtask

    initial begin
        int w;
        int n;
        w_rst = 1'b1;
        data  = 8'h00;
        valid = 3'b000;

        // Reset state.
        repeat (3) tick();
        check("rst tx", 32'(tx), 32'h7);
        check("rst ready", 32'(ready), 32'h0);
        check("rst busy", 32'(busy), 32'h0);
        check("rst done", 32'(done), 32'h0);
        w_rst = 1'b0;
        tick();
        check("ready first edge", 32'(ready), 32'h7);

        // Basic frame.
        run_frame("f55", 0, 8'h55, 1'b0, -1, w);

        // Back-to-back with valid held high: next acceptance on first idle cycle.
        run_frame("fA3", 0, 8'hA3, 1'b1, -1, w);
        run_frame("f0F", 0, 8'h0F, 1'b0, -1, w);
        check("b2b gap", 32'(w), 32'd0);
        tick();
        check("f0F done one cycle", 32'(done[0]), 32'd0);

        // Request while busy is ignored; no extra frame follows.
        run_frame("fFFpoke", 0, 8'h3C, 1'b0, 9, w);
        n = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (tx[0] !== 1'b1 || busy[0] !== 1'b0) n++;
        end
        check("no extra frame", 32'(n), 32'd0);

        // Reset in the middle of a 0x00 frame.
        data = 8'h00;
        valid[0] = 1'b1;
        tick();
        valid[0] = 1'b0;
        check("rst frame start", 32'(tx[0]), 32'd0);
        repeat (15) tick();
        w_rst = 1'b1;
        #1;
        check("midrst tx", 32'(tx[0]), 32'd1);
        check("midrst busy", 32'(busy[0]), 32'd0);
        check("midrst ready", 32'(ready[0]), 32'd0);
        n = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (done[0]) n++;
        end
        check("midrst no done", 32'(n), 32'd0);
        w_rst = 1'b0;
        run_frame("f81", 0, 8'h81, 1'b0, -1, w);
        check("f81 one edge to ready", 32'(w), 32'd1);

        // Two stop bits.
        run_frame("f3C_stop2", 1, 8'h3C, 1'b0, -1, w);

        // Parity sense (plain 8N1 frames without the parity feature).
        run_frame("f07_even", 0, 8'h07, 1'b0, -1, w);
        run_frame("f07_odd", 2, 8'h07, 1'b0, -1, w);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- 8-bit asynchronous serial transmitter, LSB first, 8N1 by default.
- Transmit-side counterpart of the board UART receiver in the uart_adaptive group.
- Takes bytes from fabric logic (Ethernet/debug path) over a valid/ready handshake and drives the TX pin.
- Idle line high; one start bit (0), 8 data bits, optional parity bit, STOP_BITS stop bits (1).

Parameters:
- CLK_FREQ, 50_000_000, i_clk frequency in Hz.
- BAUD, 115200, line rate in bit/s.
- CLKS_PER_BIT, CLK_FREQ/BAUD (434), clocks per bit cell. May be overridden directly; benches use 4.
- STOP_BITS, 1, number of stop bits. Legal values are 1 or 2.
- PARITY_ODD, 0, selects parity sense: 0 = even, 1 = odd. Used only with UART_TX_PARITY_EN.

Ports:
- i_clk  input  1  system clock.
- w_rst  input  1  reset: asynchronous, active-high.
- i_tx_data  input  8  byte to send. Sampled on the handshake edge.
- i_tx_valid  input  1  i_tx_data is valid. Must stay high until accepted.
- o_tx_ready  output  1  block can accept a byte. Registered.
- o_tx  output  1  serial line. Registered, glitch-free.
- o_tx_busy  output  1  a frame is in progress (state != IDLE).
- o_tx_done  output  1  one-cycle pulse when the last stop bit completes.

Behaviour:
- Reset is decided: w_rst, asynchronous, active-high; clock i_clk. All flops are on posedge i_clk or posedge w_rst.
- Reset values:
  - o_tx = 1
  - o_tx_ready = 0
  - o_tx_busy = 0
  - o_tx_done = 0
  - state = IDLE, bit counter = 0, cycle counter = 0, shift register = 0
- o_tx_ready rises at the first i_clk edge after w_rst deasserts.
- Handshake: a byte is accepted at an edge where i_tx_valid && o_tx_ready.
  - At that edge: i_tx_data is latched into the shift register, o_tx_ready goes to 0, o_tx goes to 0 (start bit), state goes to START.
  - i_tx_valid while o_tx_ready = 0 is ignored. i_tx_data may change after acceptance.
- State machine: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
  - Each bit cell lasts exactly CLKS_PER_BIT cycles. The cycle counter runs 0..CLKS_PER_BIT-1 and wraps to 0 at every bit boundary.
  - DATA: the bit index runs 0..7. o_tx = shift[0]; the register shifts right at each bit boundary.
  - STOP: o_tx = 1 for STOP_BITS*CLKS_PER_BIT cycles.
  - At the final STOP edge: state goes to IDLE, o_tx_done pulses for 1 cycle, o_tx_ready goes to 1 (same edge), o_tx stays 1.
- Latency: the start bit appears on o_tx 1 edge after acceptance.
- Frame length: (10 + parity + STOP_BITS - 1) * CLKS_PER_BIT cycles.
- Back-to-back: with i_tx_valid held high, the next acceptance occurs on the first IDLE cycle. The minimum inter-frame idle is therefore exactly 1 clock, so the frame period is frame length + 1.
- o_tx_busy = (state != IDLE), registered consistently with state.
- Reset mid-frame: o_tx returns to 1 immediately (asynchronously) and the frame is abandoned. No o_tx_done is issued. o_tx_ready rises on the first edge after release.
- Counter width: $clog2(CLKS_PER_BIT*STOP_BITS). CLKS_PER_BIT < 2 is illegal; flag it with an elaboration-time $error.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: a PARITY state is inserted after DATA.
  - It lasts one bit cell with o_tx = ^data XOR PARITY_ODD.
  - Parity is computed from the byte latched at acceptance.
- Undefined: no PARITY state, no parity logic, and PARITY_ODD has no effect.

Decomposition:
- Shared package uart_pkg holds:
  - state enum type tx_state_t (IDLE, START, DATA, PARITY, STOP)
  - localparam UART_DATA_W = 8
  - default CLK_FREQ and BAUD constants, shared with the receiver
- One natural sub-module: uart_baud_cnt.
  - Cycle counter with enable, clear and a bit_end pulse at CLKS_PER_BIT-1.
  - Reusable by the receiver.

Test Plan:
- Reset then send 0x55 (CLKS_PER_BIT = 4): o_tx shows 0, 1,0,1,0,1,0,1,0, 1, each bit 4 cycles. o_tx_done pulses at cycle 40 after acceptance; o_tx_ready returns high on the same edge.
- i_tx_valid held high with 0xA3 then 0x0F: two frames separated by exactly 1 idle-high cycle. Bits observed LSB first are 1,1,0,0,0,1,0,1 then 1,1,1,1,0,0,0,0.
- i_tx_valid pulsed with 0xFF while busy: byte not accepted, no extra frame, o_tx_ready remains 0 until the current frame ends.
- w_rst asserted at cycle 15 of a 0x00 frame: o_tx = 1 immediately, o_tx_busy = 0, no o_tx_done. A new byte 0x81 is accepted on the first edge after release and sent correctly.
- STOP_BITS = 2, byte 0x3C: stop phase is 8 cycles high and o_tx_done comes at cycle 44.
- UART_TX_PARITY_EN, PARITY_ODD = 0, byte 0x07: parity bit = 1, frame is 11 bits (44 cycles). With PARITY_ODD = 1 the parity bit is 0.
